// File: rtl/snitch_icache_lookup_multiport_if.sv
// Lookup/refill/flush signal bundle for snitch_icache_lookup_multiport.
// slave: the cache lookup block; master: fetch front-ends plus refill handler.
interface snitch_icache_lookup_multiport_if #(
   parameter int unsigned NumPorts  = 2,
   parameter int unsigned WayCount  = 4,
   parameter int unsigned LineCount = 128,
   parameter int unsigned LineWidth = 128,
   parameter int unsigned FetchAw   = 32,
   parameter int unsigned IdWidth   = 4
);
   localparam int unsigned LineAlign = $clog2(LineWidth / 8);
   localparam int unsigned SetBits   = $clog2(LineCount);
   localparam int unsigned TagWidth  = FetchAw - LineAlign - SetBits;
   localparam int unsigned WayW      = (WayCount > 1) ? $clog2(WayCount) : 1;

   logic                                 flush_valid_i;
   logic                                 flush_ready_o;
   logic [NumPorts-1:0][FetchAw-1:0]     in_addr_i;
   logic [NumPorts-1:0][IdWidth-1:0]     in_id_i;
   logic [NumPorts-1:0]                  in_valid_i;
   logic [NumPorts-1:0]                  in_ready_o;
   logic [NumPorts-1:0][FetchAw-1:0]     out_addr_o;
   logic [NumPorts-1:0][IdWidth-1:0]     out_id_o;
   logic [NumPorts-1:0][WayW-1:0]        out_way_o;
   logic [NumPorts-1:0]                  out_hit_o;
   logic [NumPorts-1:0][LineWidth-1:0]   out_data_o;
   logic [NumPorts-1:0]                  out_error_o;
   logic [NumPorts-1:0]                  out_valid_o;
   logic [NumPorts-1:0]                  out_ready_i;
   logic [SetBits-1:0]                   write_addr_i;
   logic [WayW-1:0]                      write_way_i;
   logic [LineWidth-1:0]                 write_data_i;
   logic [TagWidth-1:0]                  write_tag_i;
   logic                                 write_error_i;
   logic                                 write_valid_i;
   logic                                 write_ready_o;
   logic [NumPorts-1:0]                  parity_err_o;

   modport slave (
      input  flush_valid_i, in_addr_i, in_id_i, in_valid_i, out_ready_i,
             write_addr_i, write_way_i, write_data_i, write_tag_i, write_error_i, write_valid_i,
      output flush_ready_o, in_ready_o, out_addr_o, out_id_o, out_way_o, out_hit_o, out_data_o,
             out_error_o, out_valid_o, write_ready_o, parity_err_o
   );

   modport master (
      output flush_valid_i, in_addr_i, in_id_i, in_valid_i, out_ready_i,
             write_addr_i, write_way_i, write_data_i, write_tag_i, write_error_i, write_valid_i,
      input  flush_ready_o, in_ready_o, out_addr_o, out_id_o, out_way_o, out_hit_o, out_data_o,
             out_error_o, out_valid_o, write_ready_o, parity_err_o
   );
endinterface

// File: rtl/snitch_icache_lookup_multiport.sv
// Multi-port, line-interleaved banked L1 icache lookup with parallel ways.
// Optional tag parity: define SNITCH_ICACHE_LOOKUP_PARITY_EN.
module snitch_icache_lookup_multiport #(
   parameter int unsigned NumPorts  = 2,
   parameter int unsigned NumBanks  = 2,
   parameter int unsigned WayCount  = 4,
   parameter int unsigned LineCount = 128,
   parameter int unsigned LineWidth = 128,
   parameter int unsigned FetchAw   = 32,
   parameter int unsigned IdWidth   = 4
) (
   input logic                             clk_i,
   input logic                             rst_ni,
   snitch_icache_lookup_multiport_if.slave lookup_if
);
   localparam int unsigned LineAlign  = $clog2(LineWidth / 8);
   localparam int unsigned SetBits    = $clog2(LineCount);
   localparam int unsigned TagWidth   = FetchAw - LineAlign - SetBits;
   localparam int unsigned LocalCount = LineCount / NumBanks;
   localparam int unsigned LocalW     = (LocalCount > 1) ? $clog2(LocalCount) : 1;
   localparam int unsigned BankW      = (NumBanks > 1) ? $clog2(NumBanks) : 1;
   localparam int unsigned WayW       = (WayCount > 1) ? $clog2(WayCount) : 1;
   localparam int unsigned PortW      = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int unsigned ErrBit     = TagWidth;
   localparam int unsigned ValidBit   = TagWidth + 1;
`ifdef SNITCH_ICACHE_LOOKUP_PARITY_EN
   localparam int unsigned ParBit     = TagWidth + 2;
   localparam int unsigned EntryW     = TagWidth + 3;
`else
   localparam int unsigned EntryW     = TagWidth + 2;
`endif

   typedef enum logic {StInit, StIdle} state_e;
   typedef logic [EntryW-1:0] entry_t;

   state_e                               state_q, state_d;
   logic [LocalW-1:0]                    cnt_q, cnt_d;
   logic [NumBanks-1:0][PortW-1:0]       rr_q, rr_d;
   logic                                 idle;

   entry_t                               tag_q  [NumBanks][WayCount][LocalCount];
   logic [LineWidth-1:0]                 data_q [NumBanks][WayCount][LocalCount];

   logic [BankW-1:0]                     p_bank [NumPorts];
   logic [LocalW-1:0]                    p_loc  [NumPorts];
   logic [TagWidth-1:0]                  p_tag  [NumPorts];
   logic [NumPorts-1:0]                  req, grant;
   logic [BankW-1:0]                     wbank;
   logic [LocalW-1:0]                    wloc;
   logic [NumBanks-1:0]                  wr_bank;
   entry_t                               wentry;

   logic [NumPorts-1:0]                  lk_hit, lk_err;
   logic [NumPorts-1:0][WayW-1:0]        lk_way;
   logic [NumPorts-1:0][LineWidth-1:0]   lk_data;

   logic [NumPorts-1:0]                  out_valid_q, out_hit_q, out_err_q;
   logic [NumPorts-1:0][FetchAw-1:0]     out_addr_q;
   logic [NumPorts-1:0][IdWidth-1:0]     out_id_q;
   logic [NumPorts-1:0][WayW-1:0]        out_way_q;
   logic [NumPorts-1:0][LineWidth-1:0]   out_data_q;

   assign idle = (state_q == StIdle);

   // Sweep/idle sequencing: one bank-local index cleared per cycle in every bank.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StInit: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LocalW'(LocalCount - 1)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         StIdle: begin
            if (lookup_if.flush_valid_i) begin
               state_d = StInit;
               cnt_d   = '0;
            end
         end
         default: state_d = StInit;
      endcase
   end

   // State, sweep counter and per-bank round-robin pointers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StInit;
         cnt_q   <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
      end
   end

   // Address decode of lookups and of the refill port.
   always_comb begin
      logic [SetBits-1:0] set_idx;
      set_idx = '0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
         set_idx   = lookup_if.in_addr_i[p][LineAlign +: SetBits];
         p_bank[p] = BankW'(32'(set_idx) % NumBanks);
         p_loc[p]  = LocalW'(32'(set_idx) / NumBanks);
         p_tag[p]  = lookup_if.in_addr_i[p][FetchAw-1 -: TagWidth];
         req[p]    = lookup_if.in_valid_i[p] & (~out_valid_q[p] | lookup_if.out_ready_i[p]);
      end
      wbank = BankW'(32'(lookup_if.write_addr_i) % NumBanks);
      wloc  = LocalW'(32'(lookup_if.write_addr_i) / NumBanks);
      for (int unsigned b = 0; b < NumBanks; b++)
         wr_bank[b] = idle & lookup_if.write_valid_i & (wbank == BankW'(b));
   end

   // Per-bank arbitration: refill wins its bank, else round-robin over ready ports.
   always_comb begin
      logic        found;
      int unsigned cand;
      grant = '0;
      rr_d  = rr_q;
      found = 1'b0;
      cand  = 0;
      for (int unsigned b = 0; b < NumBanks; b++) begin
         found = 1'b0;
         if (idle && !wr_bank[b]) begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
               cand = (32'(rr_q[b]) + i) % NumPorts;
               if (!found && req[PortW'(cand)] && (p_bank[PortW'(cand)] == BankW'(b))) begin
                  grant[PortW'(cand)] = 1'b1;
                  found               = 1'b1;
                  rr_d[b]             = PortW'((cand + 1) % NumPorts);
               end
            end
         end
      end
   end

`ifdef SNITCH_ICACHE_LOOKUP_PARITY_EN
   logic [NumPorts-1:0] lk_perr, perr_q;
   assign wentry = {^{lookup_if.write_error_i, lookup_if.write_tag_i}, 1'b1,
                    lookup_if.write_error_i, lookup_if.write_tag_i};
`else
   assign wentry = {1'b1, lookup_if.write_error_i, lookup_if.write_tag_i};
`endif

   // Parallel-way tag compare; data is the OR of all hitting ways, way/error from the lowest hit.
   always_comb begin
      entry_t e;
      logic   way_hit;
      e       = '0;
      way_hit = 1'b0;
      lk_hit  = '0;
      lk_err  = '0;
      lk_way  = '0;
      lk_data = '0;
`ifdef SNITCH_ICACHE_LOOKUP_PARITY_EN
      lk_perr = '0;
`endif
      for (int unsigned p = 0; p < NumPorts; p++) begin
         for (int unsigned w = 0; w < WayCount; w++) begin
            e       = tag_q[p_bank[p]][w][p_loc[p]];
            way_hit = e[ValidBit] && (e[TagWidth-1:0] == p_tag[p]);
`ifdef SNITCH_ICACHE_LOOKUP_PARITY_EN
            if (e[ValidBit] && ((^e[ErrBit:0]) != e[ParBit])) begin
               way_hit    = 1'b0;
               lk_perr[p] = 1'b1;
            end
`endif
            if (wr_bank[p_bank[p]]) way_hit = 1'b0;
            if (way_hit) begin
               lk_data[p] = lk_data[p] | data_q[p_bank[p]][w][p_loc[p]];
               if (!lk_hit[p]) begin
                  lk_way[p] = WayW'(w);
                  lk_err[p] = e[ErrBit];
               end
               lk_hit[p] = 1'b1;
            end
         end
      end
   end

   // Tag/data store: sweep clears every way of every bank, otherwise the refill writes one way.
   always_ff @(posedge clk_i) begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
         for (int unsigned w = 0; w < WayCount; w++) begin
            if (state_q == StInit) begin
               tag_q[b][w][cnt_q]  <= '0;
               data_q[b][w][cnt_q] <= '0;
            end else if (wr_bank[b] && (lookup_if.write_way_i == WayW'(w))) begin
               tag_q[b][w][wloc]  <= wentry;
               data_q[b][w][wloc] <= lookup_if.write_data_i;
            end
         end
      end
   end

   // Single-entry response register per port, held until consumed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= '0;
         out_hit_q   <= '0;
         out_err_q   <= '0;
         out_addr_q  <= '0;
         out_id_q    <= '0;
         out_way_q   <= '0;
         out_data_q  <= '0;
      end else begin
         for (int unsigned p = 0; p < NumPorts; p++) begin
            if (grant[p]) begin
               out_valid_q[p] <= 1'b1;
               out_hit_q[p]   <= lk_hit[p];
               out_err_q[p]   <= lk_err[p];
               out_addr_q[p]  <= lookup_if.in_addr_i[p];
               out_id_q[p]    <= lookup_if.in_id_i[p];
               out_way_q[p]   <= lk_way[p];
               out_data_q[p]  <= lk_data[p];
            end else if (lookup_if.out_ready_i[p]) begin
               out_valid_q[p] <= 1'b0;
            end
         end
      end
   end

`ifdef SNITCH_ICACHE_LOOKUP_PARITY_EN
   // Parity fault flag travels with the response it belongs to.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) perr_q <= '0;
      else begin
         for (int unsigned p = 0; p < NumPorts; p++)
            if (grant[p]) perr_q[p] <= lk_perr[p];
      end
   end
   assign lookup_if.parity_err_o = perr_q;
`else
   assign lookup_if.parity_err_o = '0;
`endif

   assign lookup_if.flush_ready_o = idle;
   assign lookup_if.in_ready_o    = grant;
   assign lookup_if.write_ready_o = |wr_bank;
   assign lookup_if.out_valid_o   = out_valid_q;
   assign lookup_if.out_hit_o     = out_hit_q;
   assign lookup_if.out_error_o   = out_err_q;
   assign lookup_if.out_addr_o    = out_addr_q;
   assign lookup_if.out_id_o      = out_id_q;
   assign lookup_if.out_way_o     = out_way_q;
   assign lookup_if.out_data_o    = out_data_q;
endmodule

// File: tb/tb_snitch_icache_lookup_multiport.sv
// Directed bench for snitch_icache_lookup_multiport with default parameters.
module tb_snitch_icache_lookup_multiport;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   snitch_icache_lookup_multiport_if lif ();

   snitch_icache_lookup_multiport dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .lookup_if (lif)
   );

   typedef struct {
      logic [6:0]   set;
      logic [1:0]   way;
      logic [20:0]  tag;
      logic [127:0] data;
      logic         err;
   } refill_t;

   typedef struct {
      int unsigned  port;
      logic [31:0]  addr;
      logic [3:0]   id;
      logic         hit;
      logic [1:0]   way;
      logic [127:0] data;
      logic         err;
   } vec_t;

   localparam logic [127:0] DA5 = {16{8'hA5}};
   localparam logic [127:0] D2  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] D3  = {4{32'hDEAD_BEEF}};
   localparam logic [127:0] D5  = 128'hFF00_0000_0000_0000_0000_0000_0000_00F0;
   localparam logic [127:0] D6  = 128'h00F0_0000_0000_0000_0000_0000_0000_0F0F;

   refill_t refills [5];
   vec_t    vecs    [8];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_refill(input refill_t r);
      @(negedge clk);
      lif.write_addr_i  = r.set;
      lif.write_way_i   = r.way;
      lif.write_tag_i   = r.tag;
      lif.write_data_i  = r.data;
      lif.write_error_i = r.err;
      lif.write_valid_i = 1'b1;
      #1 chk("refill write_ready", 128'(lif.write_ready_o), 128'd1);
      @(posedge clk);
      #1 lif.write_valid_i = 1'b0;
   endtask

   // Issues one lookup; returns #1 after the edge at which the response registers.
   task automatic do_lookup(input int unsigned p, input logic [31:0] a, input logic [3:0] id);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      lif.in_addr_i[p]  = a;
      lif.in_id_i[p]    = id;
      lif.in_valid_i[p] = 1'b1;
      for (int c = 0; c < 20 && !ok; c++) begin
         #1;
         if (lif.in_ready_o[p]) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) chk("lookup grant timeout", 128'd0, 128'd1);
      @(posedge clk);
      #1 lif.in_valid_i[p] = 1'b0;
   endtask

   initial begin
      logic [1:0]   bad2;
      logic [127:0] held;

      lif.flush_valid_i = 1'b0;
      lif.in_addr_i     = '0;
      lif.in_id_i       = '0;
      lif.in_valid_i    = '0;
      lif.out_ready_i   = 2'b11;
      lif.write_addr_i  = '0;
      lif.write_way_i   = '0;
      lif.write_data_i  = '0;
      lif.write_tag_i   = '0;
      lif.write_error_i = 1'b0;
      lif.write_valid_i = 1'b0;

      refills[0] = '{7'd4, 2'd2, 21'h20000, DA5, 1'b0};
      refills[1] = '{7'd5, 2'd0, 21'h20000, D2,  1'b1};
      refills[2] = '{7'd4, 2'd1, 21'h12345, D3,  1'b0};
      refills[3] = '{7'd6, 2'd1, 21'h20000, D5,  1'b0};
      refills[4] = '{7'd6, 2'd3, 21'h20000, D6,  1'b1};

      vecs[0] = '{0, 32'h1000_0040, 4'h1, 1'b1, 2'd2, DA5,       1'b0};
      vecs[1] = '{1, 32'h1000_0040, 4'h2, 1'b1, 2'd2, DA5,       1'b0};
      vecs[2] = '{0, 32'h1000_0050, 4'h3, 1'b1, 2'd0, D2,        1'b1};
      vecs[3] = '{1, 32'h091A_2840, 4'h4, 1'b1, 2'd1, D3,        1'b0};
      vecs[4] = '{0, 32'h1000_0060, 4'h5, 1'b1, 2'd1, D5 | D6,   1'b0};
      vecs[5] = '{1, 32'h1000_0070, 4'h6, 1'b0, 2'd0, '0,        1'b0};
      vecs[6] = '{0, 32'h2000_0040, 4'h7, 1'b0, 2'd0, '0,        1'b0};
      vecs[7] = '{1, 32'h1000_004C, 4'h8, 1'b1, 2'd2, DA5,       1'b0};

      // Reset values, lookups already requested.
      lif.in_addr_i[0] = 32'h0000_0000;
      lif.in_addr_i[1] = 32'h0000_0010;
      lif.in_valid_i   = 2'b11;
      repeat (3) @(negedge clk);
      chk("reset in_ready",    128'(lif.in_ready_o),    128'd0);
      chk("reset out_valid",   128'(lif.out_valid_o),   128'd0);
      chk("reset write_ready", 128'(lif.write_ready_o), 128'd0);
      chk("reset flush_ready", 128'(lif.flush_ready_o), 128'd0);
      chk("reset parity_err",  128'(lif.parity_err_o),  128'd0);
      chk("reset out_data0",   lif.out_data_o[0],       128'd0);

      // Reset mid-sweep, then the full sweep from index 0.
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1 chk("mid-sweep reset flush_ready", 128'(lif.flush_ready_o), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad2 = 2'b00;
      for (int i = 0; i < 63; i++) begin
         @(posedge clk); #1;
         if (lif.in_ready_o != 2'b00 || lif.flush_ready_o) bad2 = 2'b11;
      end
      chk("sweep holds in_ready/flush_ready low", 128'(bad2), 128'd0);
      @(posedge clk); #1;
      chk("flush_ready after sweep", 128'(lif.flush_ready_o), 128'd1);
      chk("first grants", 128'(lif.in_ready_o), 128'd3);
      @(posedge clk); #1;
      lif.in_valid_i = 2'b00;
      chk("first out_valid", 128'(lif.out_valid_o), 128'd3);
      chk("first out_hit",   128'(lif.out_hit_o),   128'd0);
      chk("first data0",     lif.out_data_o[0],     128'd0);
      chk("first data1",     lif.out_data_o[1],     128'd0);

      // Refills, then table-driven lookups.
      for (int i = 0; i < 5; i++) do_refill(refills[i]);
      for (int i = 0; i < 8; i++) begin
         do_lookup(vecs[i].port, vecs[i].addr, vecs[i].id);
         chk($sformatf("v%0d out_valid", i), 128'(lif.out_valid_o[vecs[i].port]), 128'd1);
         chk($sformatf("v%0d out_hit", i),   128'(lif.out_hit_o[vecs[i].port]),   128'(vecs[i].hit));
         chk($sformatf("v%0d out_data", i),  lif.out_data_o[vecs[i].port],        vecs[i].data);
         chk($sformatf("v%0d out_error", i), 128'(lif.out_error_o[vecs[i].port]), 128'(vecs[i].err));
         chk($sformatf("v%0d out_addr", i),  128'(lif.out_addr_o[vecs[i].port]),  128'(vecs[i].addr));
         chk($sformatf("v%0d out_id", i),    128'(lif.out_id_o[vecs[i].port]),    128'(vecs[i].id));
         chk($sformatf("v%0d parity_err", i), 128'(lif.parity_err_o[vecs[i].port]), 128'd0);
         if (vecs[i].hit) chk($sformatf("v%0d out_way", i), 128'(lif.out_way_o[vecs[i].port]), 128'(vecs[i].way));
      end

      // Two ports on bank 0 alternate; the last bank-0 grant went to port 1, so port 0 leads.
      // A bank-1 refill runs alongside and is never blocked.
      @(negedge clk);
      lif.in_addr_i[0]  = 32'h1000_0040;
      lif.in_addr_i[1]  = 32'h1000_0000;
      lif.in_valid_i    = 2'b11;
      lif.write_addr_i  = 7'd7;
      lif.write_way_i   = 2'd0;
      lif.write_tag_i   = 21'h00001;
      lif.write_data_i  = '0;
      lif.write_error_i = 1'b0;
      lif.write_valid_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("rr grant %0d", k), 128'(lif.in_ready_o), (k % 2 == 0) ? 128'd1 : 128'd2);
         chk($sformatf("rr write_ready %0d", k), 128'(lif.write_ready_o), 128'd1);
         @(negedge clk);
      end
      lif.in_valid_i    = 2'b00;
      lif.write_valid_i = 1'b0;
      repeat (2) @(negedge clk);

      // Port 1 backpressure for 5 cycles; port 0 keeps flowing.
      lif.out_ready_i   = 2'b01;
      lif.in_addr_i[1]  = 32'h1000_0040;
      lif.in_id_i[1]    = 4'h5;
      lif.in_valid_i[1] = 1'b1;
      #1 chk("bp first grant p1", 128'(lif.in_ready_o[1]), 128'd1);
      @(posedge clk); #1;
      held = lif.out_data_o[1];
      chk("bp p1 data", held, DA5);
      lif.in_addr_i[1]  = 32'h1000_0050;
      lif.in_id_i[1]    = 4'h6;
      lif.in_addr_i[0]  = 32'h1000_0060;
      lif.in_valid_i[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk($sformatf("bp in_ready %0d", k), 128'(lif.in_ready_o), 128'd1);
         chk($sformatf("bp p1 valid %0d", k), 128'(lif.out_valid_o[1]), 128'd1);
         chk($sformatf("bp p1 data %0d", k), lif.out_data_o[1], DA5);
         chk($sformatf("bp p1 id %0d", k), 128'(lif.out_id_o[1]), 128'd5);
      end
      @(negedge clk);
      lif.out_ready_i = 2'b11;
      #1 chk("bp release grant p1", 128'(lif.in_ready_o[1]), 128'd1);
      @(posedge clk); #1;
      lif.in_valid_i = 2'b00;
      chk("bp new id p1",   128'(lif.out_id_o[1]),    128'd6);
      chk("bp new data p1", lif.out_data_o[1],         D2);
      chk("bp new err p1",  128'(lif.out_error_o[1]), 128'd1);

      // Bank-0 refill blocks only the bank-0 lookup.
      @(negedge clk);
      lif.in_addr_i[0]  = 32'h1000_0040;
      lif.in_addr_i[1]  = 32'h1000_0050;
      lif.in_valid_i    = 2'b11;
      lif.write_addr_i  = 7'd8;
      lif.write_way_i   = 2'd0;
      lif.write_valid_i = 1'b1;
      #1;
      chk("bank-0 refill blocks p0 only", 128'(lif.in_ready_o), 128'd2);
      chk("bank-0 refill write_ready", 128'(lif.write_ready_o), 128'd1);
      @(negedge clk);
      lif.in_valid_i    = 2'b00;
      lif.write_valid_i = 1'b0;
      repeat (2) @(negedge clk);

      // Flush accepted together with a lookup granted in the same cycle.
      lif.flush_valid_i = 1'b1;
      lif.in_addr_i[0]  = 32'h1000_0050;
      lif.in_id_i[0]    = 4'h9;
      lif.in_valid_i[0] = 1'b1;
      #1;
      chk("flush_ready idle", 128'(lif.flush_ready_o), 128'd1);
      chk("lookup with flush granted", 128'(lif.in_ready_o[0]), 128'd1);
      @(posedge clk); #1;
      lif.flush_valid_i = 1'b0;
      lif.in_valid_i    = 2'b00;
      chk("flush-cycle lookup hit", 128'(lif.out_hit_o[0]),   128'd1);
      chk("flush-cycle lookup err", 128'(lif.out_error_o[0]), 128'd1);
      bad2 = 2'b00;
      for (int i = 0; i < 63; i++) begin
         @(posedge clk); #1;
         if (lif.flush_ready_o || lif.write_ready_o) bad2 = 2'b01;
      end
      chk("flush sweep holds ready low", 128'(bad2), 128'd0);
      @(posedge clk); #1;
      chk("flush_ready after flush sweep", 128'(lif.flush_ready_o), 128'd1);
      do_lookup(0, 32'h1000_0050, 4'hA);
      chk("post-flush hit",  128'(lif.out_hit_o[0]),   128'd0);
      chk("post-flush data", lif.out_data_o[0],        128'd0);
      chk("post-flush err",  128'(lif.out_error_o[0]), 128'd0);
      do_lookup(1, 32'h1000_0040, 4'hB);
      chk("post-flush hit p1", 128'(lif.out_hit_o[1]), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
